// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Holds a small table of {duty, resolution, hold} steps and plays them back
// into a PWM core. New values are only applied when the core reports a period
// wrap (period_end), so the pulse train never glitches mid-period.
//
// Optional feature macro: PWMSEQ_LOOP_EN
//   defined   : loop_en is honored and loop_cnt counts wraps back to entry 0
//               (saturating at all-ones, cleared on start).
//   undefined : loop_en is ignored; every sequence ends with a done pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_valid/wr_ready table write handshake; a write happens in any cycle
//                     where wr_valid && wr_ready. The producer holds
//                     wr_addr/wr_duty/wr_res/wr_hold stable while wr_valid is
//                     high; wr_ready is high only in IDLE and never depends on
//                     wr_valid.
//   wr_addr/duty/res/hold  entry payload (res saturated to 5..16 on store)
//   num_steps         entries to play (1..DEPTH), sampled on start
//   start, stop       playback control pulses
//   loop_en           wrap to entry 0 after the last step (macro-gated)
//   period_end        one-cycle wrap strobe from the PWM core
//   duty, res         values driven to the PWM core
//   step_idx          entry currently applied
//   busy              high in ARM or RUN
//   done              one-cycle pulse when a non-looping sequence completes
//   loop_cnt          loop pass counter (only with PWMSEQ_LOOP_EN)
//   state_dbg         FSM state: 0=IDLE, 1=ARM, 2=RUN
//
// The step table is not reset, so its contents survive a reset.
// ---------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DUTY_W = 16,
    parameter int HOLD_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DUTY_W-1:0]          wr_duty,
    input  logic [4:0]                 wr_res,
    input  logic [HOLD_W-1:0]          wr_hold,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       period_end,
    output logic [DUTY_W-1:0]          duty,
    output logic [4:0]                 res,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       busy,
    output logic                       done,
`ifdef PWMSEQ_LOOP_EN
    output logic [HOLD_W-1:0]          loop_cnt,
`endif
    output logic [1:0]                 state_dbg
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Step table
    logic [DUTY_W-1:0] duty_tab [DEPTH];
    logic [4:0]        res_tab  [DEPTH];
    logic [HOLD_W-1:0] hold_tab [DEPTH];

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [4:0]        res_q, res_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W:0]    steps_q, steps_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] loop_q, loop_d;

    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic              start_ok;
    logic              loop_act;

`ifdef PWMSEQ_LOOP_EN
    assign loop_act = loop_en;
    assign loop_cnt = loop_q;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_act       = 1'b0;
`endif

    // Resolution is saturated once at write time so every load sees 5..16.
    function automatic logic [4:0] res_sat(input logic [4:0] r);
        if (r < 5'd5)       res_sat = 5'd5;
        else if (r > 5'd16) res_sat = 5'd16;
        else                res_sat = r;
    endfunction

    // duty = 2^res is allowed (100% high), anything above is clamped to it.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d,
                                                     input logic [4:0] r);
        logic [DUTY_W:0] lim;
        lim = {{DUTY_W{1'b0}}, 1'b1} << r;
        if ({1'b0, d} > lim) clamp_duty = lim[DUTY_W-1:0];
        else                 clamp_duty = d;
    endfunction

    assign wr_ready = (state_q == S_IDLE);
    assign start_ok = (num_steps != '0) && (num_steps <= (IDX_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready) begin
            duty_tab[wr_addr] <= wr_duty;
            res_tab[wr_addr]  <= res_sat(wr_res);
            hold_tab[wr_addr] <= wr_hold;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        res_d    = res_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        steps_d  = steps_q;
        done_d   = 1'b0;
        loop_d   = loop_q;
        load_en  = 1'b0;
        load_idx = '0;

        case (state_q)
            S_IDLE: begin
                if (stop) duty_d = '0;
                if (start && start_ok) begin
                    state_d = S_ARM;
                    steps_d = num_steps;
                    loop_d  = '0;
                end
            end
            S_ARM: begin
                // stop wins over a coincident boundary
                if (stop) begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                end else if (period_end) begin
                    state_d = S_RUN;
                    load_en = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                end else if (period_end) begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if ({1'b0, idx_q} == steps_q - 1'b1) begin
                        if (loop_act) begin
                            load_en = 1'b1;
                            if (loop_q != '1) loop_d = loop_q + 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        load_en  = 1'b1;
                        load_idx = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            duty_d = clamp_duty(duty_tab[load_idx], res_tab[load_idx]);
            res_d  = res_tab[load_idx];
            idx_d  = load_idx;
            hold_d = hold_tab[load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            res_q   <= 5'd5;
            idx_q   <= '0;
            hold_q  <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            steps_q <= steps_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
        end
    end

    assign duty      = duty_q;
    assign res       = res_q;
    assign step_idx  = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;

    logic        clk, rst;
    logic        wr_valid, wr_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_duty;
    logic [4:0]  wr_res;
    logic [7:0]  wr_hold;
    logic [2:0]  num_steps;
    logic        start, stop, loop_en, period_end;
    logic [15:0] duty;
    logic [4:0]  res;
    logic [1:0]  step_idx;
    logic        busy, done;
    logic [1:0]  state_dbg;
`ifdef PWMSEQ_LOOP_EN
    logic [7:0]  loop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference table, holding the values as the spec says they are stored.
    int m_duty [4];
    int m_res  [4];
    int m_hold [4];

    pwm_duty_sequencer #(.DEPTH(4), .DUTY_W(16), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_duty    (wr_duty),
        .wr_res     (wr_res),
        .wr_hold    (wr_hold),
        .num_steps  (num_steps),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .period_end (period_end),
        .duty       (duty),
        .res        (res),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
`ifdef PWMSEQ_LOOP_EN
        .loop_cnt   (loop_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model helpers ----------------
    function automatic int model_res(input int r);
        if (r < 5) return 5;
        if (r > 16) return 16;
        return r;
    endfunction

    function automatic int model_duty(input int i);
        int lim;
        lim = 1 << m_res[i];
        return (m_duty[i] > lim) ? lim : m_duty[i];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_entry(input int a, input int d, input int r, input int h);
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready: got %0b expected 1", wr_ready);
        end
        checks++;
        wr_valid = 1'b1;
        wr_addr  = 2'(a);
        wr_duty  = 16'(d);
        wr_res   = 5'(r);
        wr_hold  = 8'(h);
        tick();
        wr_valid = 1'b0;
        m_duty[a] = d;
        m_res[a]  = model_res(r);
        m_hold[a] = h;
    endtask

    task automatic strobe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    // Plays n entries and checks every boundary against the expanded
    // expectation list (entry i repeated hold[i]+1 times).
    task automatic run_seq(input int n, input bit pe_with_start, input bit wr_during, input bit lp);
        logic [22:0] exp_q[$];
        logic [22:0] e, last_e;
        logic [15:0] pd;
        int gap, nd, nr, nh;
        exp_q = {};
        for (int i = 0; i < n; i++)
            for (int h = 0; h <= m_hold[i]; h++)
                exp_q.push_back({16'(model_duty(i)), 5'(m_res[i]), 2'(i)});
        last_e = '0;
        loop_en = lp;
        num_steps = 3'(n);
        pd = duty;
        start = 1'b1;
        period_end = pe_with_start;
        tick();
        start = 1'b0;
        period_end = 1'b0;
        checks++;
        if (busy !== 1'b1 || duty !== pd) begin
            errors++;
            $display("FAIL seq_arm: busy=%0b duty=%0d expected busy=1 duty=%0d", busy, duty, pd);
        end
        nd = $urandom_range(0, 300); nr = $urandom_range(0, 31); nh = $urandom_range(0, 2);
        if (wr_during) begin
            wr_valid = 1'b1;
            wr_addr  = 2'(n - 1);
            wr_duty  = 16'(nd);
            wr_res   = 5'(nr);
            wr_hold  = 8'(nh);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                if ($urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                    num_steps = 3'($urandom_range(0, 7));
                end
                tick();
                start = 1'b0;
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_gap: done=%0b busy=%0b wr_ready=%0b expected 0,1,0", done, busy, wr_ready);
                end
            end
            strobe();
            checks++;
            if ({duty, res, step_idx} !== e || busy !== 1'b1 || done !== 1'b0 || wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL seq_step: duty=%0d res=%0d idx=%0d busy=%0b done=%0b expected duty=%0d res=%0d idx=%0d busy=1 done=0",
                         duty, res, step_idx, busy, done, e[22:7], e[6:2], e[1:0]);
            end
            last_e = e;
        end
        strobe();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {duty, res} !== last_e[22:2]) begin
            errors++;
            $display("FAIL seq_done: done=%0b busy=%0b duty=%0d res=%0d expected 1,0,%0d,%0d",
                     done, busy, duty, res, last_e[22:7], last_e[6:2]);
        end
        if (wr_during) begin
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL seq_wr_after: wr_ready=%0b expected 1", wr_ready);
            end
            tick();
            wr_valid = 1'b0;
            m_duty[n-1] = nd;
            m_res[n-1]  = model_res(nr);
            m_hold[n-1] = nh;
        end else begin
            tick();
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL seq_done_width: done=%0b expected 0", done);
        end
        loop_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (duty !== 16'd0 || res !== 5'd5 || step_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: duty=%0d res=%0d idx=%0d expected 0,5,0", duty, res, step_idx);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b wr_ready=%0b state=%0d expected 0,0,1,0",
                     busy, done, wr_ready, state_dbg);
        end
    endtask

    task automatic test_basic();
        int exp_d[4] = '{8, 16, 16, 16};
        write_entry(0, 8, 5, 0);
        write_entry(1, 16, 5, 1);
        num_steps = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || duty !== 16'd0) begin
            errors++;
            $display("FAIL basic_start: busy=%0b duty=%0d expected 1,0", busy, duty);
        end
        for (int k = 0; k < 4; k++) begin
            strobe();
            checks++;
            if (duty !== 16'(exp_d[k]) || done !== (k == 3) || busy !== (k != 3)) begin
                errors++;
                $display("FAIL basic_strobe%0d: duty=%0d done=%0b busy=%0b expected %0d,%0b,%0b",
                         k, duty, done, busy, exp_d[k], k == 3, k != 3);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: busy=%0b done=%0b expected 0,0", busy, done);
        end
    endtask

    task automatic test_clamp();
        int td[3] = '{40, 100, 65535};
        int tr[3] = '{5, 3, 20};
        int ed[3] = '{32, 32, 65535};
        int er[3] = '{5, 5, 16};
        for (int k = 0; k < 3; k++) begin
            write_entry(0, td[k], tr[k], 0);
            num_steps = 3'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            strobe();
            checks++;
            if (duty !== 16'(ed[k]) || res !== 5'(er[k])) begin
                errors++;
                $display("FAIL clamp%0d: duty=%0d res=%0d expected %0d,%0d", k, duty, res, ed[k], er[k]);
            end
            strobe();
            tick();
        end
    endtask

    task automatic test_stop();
        write_entry(0, 8, 5, 1);
        write_entry(1, 12, 6, 0);
        num_steps = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe();
        stop = 1'b1;
        period_end = 1'b1;
        tick();
        stop = 1'b0;
        period_end = 1'b0;
        checks++;
        if (busy !== 1'b0 || duty !== 16'd0 || done !== 1'b0 || step_idx !== 2'd0 || res !== 5'd5) begin
            errors++;
            $display("FAIL stop_run: busy=%0b duty=%0d done=%0b idx=%0d res=%0d expected 0,0,0,0,5",
                     busy, duty, done, step_idx, res);
        end
        tick();
        checks++;
        if (done !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL stop_nodone: done=%0b state=%0d expected 0,0", done, state_dbg);
        end
        // stop while armed
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        strobe();
        checks++;
        if (busy !== 1'b0 || duty !== 16'd0) begin
            errors++;
            $display("FAIL stop_arm: busy=%0b duty=%0d expected 0,0", busy, duty);
        end
        // stop in IDLE after a completed sequence clears the held duty
        num_steps = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) strobe();
        checks++;
        if (busy !== 1'b0 || duty !== 16'd8) begin
            errors++;
            $display("FAIL stop_pre_idle: busy=%0b duty=%0d expected 0,8", busy, duty);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (duty !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: duty=%0d busy=%0b expected 0,0", duty, busy);
        end
    endtask

    task automatic test_bad_start();
        int bad[2] = '{0, 5};
        logic [15:0] pd;
        for (int k = 0; k < 2; k++) begin
            pd = duty;
            num_steps = 3'(bad[k]);
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || wr_ready !== 1'b1 || duty !== pd) begin
                errors++;
                $display("FAIL bad_start%0d: busy=%0b wr_ready=%0b duty=%0d expected 0,1,%0d",
                         bad[k], busy, wr_ready, duty, pd);
            end
            strobe();
            checks++;
            if (busy !== 1'b0 || duty !== pd) begin
                errors++;
                $display("FAIL bad_start_pe%0d: busy=%0b duty=%0d expected 0,%0d", bad[k], busy, duty, pd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            write_entry(i, $urandom_range(1, 200), $urandom_range(0, 31), $urandom_range(0, 2));
        num_steps = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe();
        strobe();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (duty !== 16'd0 || res !== 5'd5 || step_idx !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: duty=%0d res=%0d idx=%0d busy=%0b done=%0b wr_ready=%0b expected 0,5,0,0,0,1",
                     duty, res, step_idx, busy, done, wr_ready);
        end
        run_seq(4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_busy();
        write_entry(0, 30, 7, 1);
        write_entry(1, 50, 8, 1);
        run_seq(2, 1'b0, 1'b1, 1'b0);
        run_seq(2, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef PWMSEQ_LOOP_EN
    task automatic test_loop();
        write_entry(0, 20, 6, 0);
        loop_en = 1'b1;
        num_steps = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe();
        for (int k = 1; k <= 5; k++) begin
            strobe();
            checks++;
            if (duty !== 16'd20 || step_idx !== 2'd0 || loop_cnt !== 8'(k) || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL loop%0d: duty=%0d idx=%0d cnt=%0d done=%0b busy=%0b expected 20,0,%0d,0,1",
                         k, duty, step_idx, loop_cnt, done, busy, k);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit lp;
        repeat (8) begin
            for (int i = 0; i < 4; i++)
                write_entry(i, $urandom_range(0, 300), $urandom_range(0, 31), $urandom_range(0, 2));
`ifdef PWMSEQ_LOOP_EN
            lp = 1'b0;
`else
            lp = 1'($urandom_range(0, 1));
`endif
            run_seq($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lp);
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_duty = '0; wr_res = '0; wr_hold = '0;
        num_steps = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; period_end = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_stop();
        test_bad_start();
        test_write_busy();
        test_reset_mid();
`ifdef PWMSEQ_LOOP_EN
        test_loop();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Programs and sequences the duty/resolution settings of the PWM pulse generator. It holds a small step table, each entry being {duty, resolution, hold}, and plays it back one entry at a time. Each new value is applied only at a PWM period boundary, so the pulse train never glitches. The block sits between the control/register logic and the PWM core's duty and bit-width inputs.

## Interface
- DEPTH, 4, number of step-table entries (power of two)
- DUTY_W, 16, duty word width; maximum resolution is 16 bits
- HOLD_W, 8, per-step hold counter width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  table write request
- wr_ready  out  1  table write accepted when wr_valid && wr_ready
- wr_addr  in  log2(DEPTH)  entry index to write
- wr_duty  in  DUTY_W  duty count (high ticks per period)
- wr_res  in  5  period bit-width, valid range 5..16
- wr_hold  in  HOLD_W  entry stays applied for wr_hold+1 periods
- num_steps  in  log2(DEPTH)+1  entries to play (1..DEPTH), sampled on start
- start  in  1  begin playback (pulse)
- stop  in  1  abort playback (pulse)
- loop_en  in  1  restart from entry 0 after the last step (see Configuration)
- period_end  in  1  one-cycle strobe from the PWM core at counter wrap
- duty  out  DUTY_W  duty to the PWM core
- res  out  5  bit-width to the PWM core
- step_idx  out  log2(DEPTH)  entry currently applied
- busy  out  1  high in ARM or RUN
- done  out  1  one-cycle pulse when a non-looping sequence completes

## Operation
- States:
  - IDLE: wr_ready=1.
  - ARM: wait for a boundary.
  - RUN: play entries.
- Table writes are accepted only in IDLE; wr_ready=0 in ARM/RUN.
- IDLE → ARM on start, when num_steps is in 1..DEPTH. start with num_steps=0 or >DEPTH is ignored.
- ARM → RUN on period_end:
  - load entry 0 into duty/res;
  - step_idx=0;
  - hold_cnt=hold[0].
- RUN, on each period_end:
  - if hold_cnt≠0, decrement it;
  - else advance to the next entry and load its duty, res and hold.
- Past the last entry (idx = num_steps−1, hold_cnt=0, period_end):
  - loop_en=1: reload entry 0.
  - loop_en=0: go to IDLE, pulse done; duty/res keep the last entry's values.
- stop in ARM or RUN:
  - go to IDLE; duty←0; res unchanged; done not pulsed.
  - stop has priority over a simultaneous period_end.
- stop in IDLE forces duty←0.
- start while busy is ignored.
- Arithmetic rules on entry load:
  - wr_res<5 is stored as 5; wr_res>16 is stored as 16.
  - Applied duty = min(duty, 2^res), so duty=2^res gives 100%.
- A write in the same cycle as start (both in IDLE) is committed. ARM reads the table no earlier than the next cycle, so the new data is used.
- Reset mid-sequence: all state returns to reset values on the next edge; the table contents are preserved.

## Timing
- Reset values:
  - duty=0, res=5, step_idx=0;
  - busy=0, done=0;
  - wr_ready=1 in the first cycle after rst deasserts;
  - state=IDLE.
- start at cycle t → busy=1 at t+1.
- period_end at cycle t (ARM or RUN) → new duty/res/step_idx visible at t+1, so the PWM core picks them up for the following period.
- period_end in the same cycle as start is not treated as a boundary; ARM is entered first.
- done is high for exactly one cycle, coincident with busy falling.
- Each entry is applied for exactly hold+1 period_end strobes.
- period_end strobes on consecutive cycles are each counted.

## Configuration
- PWMSEQ_LOOP_EN defined:
  - loop_en is honored;
  - a loop pass counter (HOLD_W bits) increments on every wrap to entry 0 and saturates at all-ones.
- PWMSEQ_LOOP_EN undefined:
  - loop_en is ignored and treated as 0;
  - every sequence ends with done.

## Test plan
- Reset, then write entries {0:duty=8,res=5,hold=0}, {1:duty=16,res=5,hold=1}; num_steps=2; start; 4 period_end strobes:
  - duty goes 0→8→16→16;
  - done pulses one cycle after the 3rd strobe;
  - busy=0 afterwards.
- Entry {duty=40,res=5}; start; period_end → duty=32 (clamped). Entry {duty=100,res=3} → res=5, duty=32.
- stop in the same cycle as period_end during RUN:
  - next cycle state=IDLE, duty=0, done=0;
  - step_idx unchanged.
- PWMSEQ_LOOP_EN defined, loop_en=1, num_steps=1, hold=0:
  - each period_end reloads entry 0;
  - loop counter increments once per strobe;
  - done never asserts.
- wr_valid during RUN:
  - wr_ready=0 and the table is unchanged;
  - after completion the write is accepted in IDLE on the first cycle.
- start with num_steps=0: busy stays 0 and no state change occurs.
